alu_ctrl_mc: RTL
================

ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width; legal values 8..64, multiple of MUL_STEP.
REQ-002 SHALL have parameter MUL_STEP, default 1: multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  instruction present in EX this cycle.
REQ-006 SHALL have port ALU_op_i  input  2  main-decoder ALU op class.
REQ-007 SHALL have port funct_i  input  6  R-type funct field.
REQ-008 SHALL have port rs_data_i  input  DATA_W  multiplicand.
REQ-009 SHALL have port rt_data_i  input  DATA_W  multiplier.
REQ-010 SHALL have port ALU_Ctrl_o  output  3  single-cycle ALU control code.
REQ-011 SHALL have port stall_o  output  1  hold IF/ID/EX; multi-cycle op in flight.
REQ-012 SHALL have port result_o  output  DATA_W  low DATA_W bits of product.
REQ-013 SHALL have port result_valid_o  output  1  result_o valid; one-cycle pulse.

Function
REQ-014 ALU_Ctrl_o SHALL be combinational: op 00 -> 000 (add); 01 -> 010 (sub); 10 -> funct_i[2:0], except funct_i=011000 -> 111 (mul); 11 -> 001 (or).
REQ-015 A mul request SHALL be valid_i=1, ALU_op_i=10, funct_i=011000.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE: mul request -> capture rs_data_i, rt_data_i, clear accumulator, load counter with N=DATA_W/MUL_STEP, go BUSY; otherwise stay IDLE.
REQ-018 stall_o SHALL be 1 combinationally in IDLE when a mul request is present, and 1 throughout BUSY; 0 in DONE and otherwise.
REQ-019 BUSY: each cycle add (multiplicand x low MUL_STEP bits of multiplier) to accumulator, shift multiplicand left and multiplier right by MUL_STEP, decrement counter; on counter reaching 0 go DONE.
REQ-020 Arithmetic SHALL be modulo 2^DATA_W; overflow discarded; low half identical for signed and unsigned operands.
REQ-021 DONE: result_valid_o=1, result_o=product, then unconditionally IDLE next cycle.
REQ-022 Total stall SHALL be N+1 cycles: request at cycle T, DONE at T+N+1.
REQ-023 Inputs in BUSY/DONE SHALL be ignored; a held mul request in DONE SHALL NOT restart.
REQ-024 result_o SHALL hold last product until next DONE; result_valid_o 0 outside DONE.
REQ-025 Zero operand SHALL still take full N cycles (no early termination).
REQ-026 Non-mul requests SHALL never assert stall_o.

Reset
REQ-027 rst_i=1 SHALL immediately force IDLE, stall_o=0, result_valid_o=0, result_o=0, counter/accumulator/operands 0, including mid-BUSY.
REQ-028 After rst_i release, first rising edge SHALL be evaluated from IDLE.

Configuration
REQ-029 Macro ALU_CTRL_MC_FLUSH_EN SHALL control a flush_i input (1 bit).
REQ-030 Defined: flush_i=1 forces stall_o=0 combinationally, suppresses IDLE start, and forces next state IDLE from BUSY or DONE; no result_valid_o for aborted op; result_o unchanged.
REQ-031 Undefined: flush_i port absent; behaviour per REQ-014..026 only.

Verification
REQ-032 Decode sweep: ALU_op 00/01/11, op 10 with funct 100000, 100010, 011000 -> ALU_Ctrl_o 000/010/001, 000, 010, 111; stall_o 0 except mul.
REQ-033 DATA_W=32, MUL_STEP=1: mul 7 x 6 at T -> stall_o 1 for T..T+32, result_valid_o=1 and result_o=42 at T+33, stall_o 0.
REQ-034 Wrap: FFFFFFFF x 2 -> result_o=FFFFFFFE; 80000000 x 80000000 -> 00000000; MUL_STEP=4 -> DONE at T+9.
REQ-035 Back-to-back: mul held through DONE, next mul 3 x 5 at DONE+1 -> single restart, result 15 after 33 stall cycles, no double start.
REQ-036 Reset mid-op: rst_i pulse at BUSY cycle 10 -> stall_o, result_valid_o, result_o 0 asynchronously; IDLE after release, no DONE.
REQ-037 With ALU_CTRL_MC_FLUSH_EN: flush_i at BUSY cycle 5 -> stall_o 0 that cycle, IDLE next, no result_valid_o, result_o keeps previous 42.

Source files
------------

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with a multi-cycle shift-add multiplier (MUL_STEP bits per cycle).
// Optional macro ALU_CTRL_MC_FLUSH_EN adds a flush_i input that aborts an in-flight multiply.
module alu_ctrl_mc #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALU_op_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
`ifdef ALU_CTRL_MC_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic [2:0]        ALU_Ctrl_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o
);

    localparam int N     = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mul_req, flush, start, last_step;
    logic [DATA_W-1:0] acc_step;

    // Sum of the multiplicand shifted by each set bit of the current multiplier slice.
    function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] m,
                                                  input logic [MUL_STEP-1:0] b);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (b[i]) s = s + (m << i);
        end
        return s;
    endfunction

`ifdef ALU_CTRL_MC_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign mul_req   = valid_i && (ALU_op_i == 2'b10) && (funct_i == FUNCT_MUL);
    assign last_step = (cnt_q == CNT_W'(1));
    assign acc_step  = acc_q + partial(mcand_q, mplier_q[MUL_STEP-1:0]);
    assign result_o  = result_q;

    always_comb begin
        ALU_Ctrl_o = 3'b000;
        case (ALU_op_i)
            2'b00:   ALU_Ctrl_o = 3'b000;
            2'b01:   ALU_Ctrl_o = 3'b010;
            2'b10:   ALU_Ctrl_o = (funct_i == FUNCT_MUL) ? 3'b111 : funct_i[2:0];
            default: ALU_Ctrl_o = 3'b001;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Stall in IDLE is combinational so the request cycle itself is held; reset overrides it.
    always_comb begin
        state_d        = state_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        start          = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_req && !flush && !rst_i) begin
                    stall_o = 1'b1;
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = !flush;
                if (flush)          state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (start) begin
            mcand_q  <= rs_data_i;
            mplier_q <= rt_data_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(N);
        end else if (state_q == BUSY && !flush) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q - CNT_W'(1);
            // result_o only changes when a product completes; aborted ops leave it alone.
            if (last_step) result_q <= acc_step;
        end
    end

endmodule
